xu_alu_sched: RTL and testbench
===============================

Name: xu_alu_sched

Overview:
Per-thread issue scheduler that shares the single integer ALU among THREADS requesters. It buffers decoded ALU ops per thread and arbitrates round-robin, one issue per cycle. It drives the ALU ex1 controls (act, instr) and tracks thread ownership of the ex1/ex2/ex3 stages. It handles flushes and ex3 trap results, blocking a trapping thread until software-visible handling completes.

Parameters:
THREADS, 4, number of requesting threads (2..4)
DEPTH, 2, per-thread op buffer entries (power of 2, >=2)
TID_W, 2, thread-id width; must be >= clog2(THREADS)

Ports:
nclk  in  1  clock
rst  in  1  synchronous active-high reset
req_vld  in  THREADS  per-thread push strobe
req_instr  in  32*THREADS  per-thread instruction; thread t occupies bits [32t +: 32]
req_rdy  out  THREADS  per-thread buffer not full
alu_stall  in  1  ALU cannot accept an ex1 op this cycle
flush  in  THREADS  per-thread flush of buffered and in-flight ops
trap_val  in  1  ALU ex3 trap indication (alu_dec_ex3_trap_val)
trap_clr  in  THREADS  release trap hold for thread
dec_alu_ex1_act  out  1  ex1 op valid / ALU clock-gate enable
dec_alu_ex1_instr  out  32  ex1 instruction
ex1_tid, ex2_tid, ex3_tid  out  TID_W each  stage owner
ex2_vld, ex3_vld  out  1 each  stage valid
trap_hold  out  THREADS  thread blocked by trap
trap_tid_vld  out  1  one-cycle pulse: trap accepted
trap_tid  out  TID_W  thread that trapped

Behaviour:
- Reset: all FIFOs empty; req_rdy all 1 on the first cycle after reset; all valids, act, trap_hold and trap_tid_vld 0; tids, instr 0; RR pointer 0.
- Buffer: per-thread FIFO with DEPTH entries. req_rdy[t] = (count[t] < DEPTH), registered-state based only; no same-cycle pop credit. A push with req_rdy[t]=0 is ignored and the FIFO is unchanged (bench checks this).
- Push in cycle N makes the entry eligible in cycle N+1 (no bypass).
- Eligible[t] = FIFO nonempty & !trap_hold[t] & !flush[t].
- Arbitration: when alu_stall=0, grant the first eligible thread at or after the RR pointer, wrapping modulo THREADS. Pop the head of the granted thread's FIFO. Then pointer = (grant+1) mod THREADS. No grant leaves the pointer unchanged.
- ex1 stage is registered: a grant in cycle N gives dec_alu_ex1_act=1, instr and ex1_tid in cycle N+1.
- ex2 follows ex1 by 1 cycle; ex3 follows ex2 by 1 cycle. Issue to ex3_vld latency = 2 cycles after act.
- alu_stall=1: no grant; ex1 drops to act=0 next cycle; ex2/ex3 keep advancing (stall holds issue only).
- Flush[t] in cycle N:
  - thread t FIFO empties at N+1;
  - any ex1/ex2/ex3 stage owned by t is invalidated at N+1 instead of advancing;
  - a same-cycle push from t is dropped;
  - flush wins over push and over grant.
- Trap: ex3_vld & trap_val & !flush[ex3_tid] in cycle N gives, at N+1:
  - trap_hold[ex3_tid]=1, trap_tid_vld=1, trap_tid=ex3_tid;
  - that thread's FIFO emptied;
  - its ex1/ex2 ops invalidated.
- trap_val with ex3_vld=0 is ignored.
- trap_clr[t] clears trap_hold[t] at N+1. If a set and a clear for the same thread occur in the same cycle, set wins.
- Held threads still accept pushes (req_rdy normal) but never win arbitration.
- Reset mid-operation discards all state in the same edge; no partial drain.
- Power: dec_alu_ex1_act doubles as ALU act. dec_alu_ex1_instr holds its value when act=0.

Test Plan:
1. Reset, then push op A to threads 0..3 in one cycle → act on 4 consecutive cycles (from 2 cycles after push), ex1_tid 0,1,2,3; ex3_vld tids 0..3 two cycles later each.
2. Thread 1 only, push 3 ops back-to-back with DEPTH=2 → req_rdy[1]=0 after 2 pushes, third push ignored; exactly 2 act cycles, tid 1.
3. Threads 0 and 2 continuously requesting, alu_stall=1 for 3 cycles mid-stream → act=0 for exactly those 3 issue slots; grant order resumes alternating 0,2 with no op lost or duplicated.
4. Thread 2 op in ex2 while thread 3 is in ex1; assert flush[2] → next cycle ex3_vld=0 and thread 3 op continues to ex3 normally; thread 2 FIFO count 0.
5. ex3_vld=1, ex3_tid=1, trap_val=1 → trap_tid_vld pulse, trap_tid=1, trap_hold=4'b0010. Thread 1 pushes accepted but not issued. trap_clr[1] → issue resumes 2 cycles later.
6. Same-cycle trap set and trap_clr for thread 0 → trap_hold[0]=1. Same-cycle push and flush on thread 3 → FIFO stays empty, no act for tid 3.

Source files
------------

// File: rtl/xu_alu_sched.sv
`default_nettype none
// ============================================================================
// Module      : xu_alu_sched
// Description : Per-thread ALU op buffers with round-robin single issue,
//               ex1..ex3 ownership tracking, flush and ex3 trap hold.
// Revision    : 1.0 - initial release
// ============================================================================
module xu_alu_sched #(
    parameter int THREADS = 4,
    parameter int DEPTH   = 2,
    parameter int TID_W   = 2
) (
    input  logic                    nclk,
    input  logic                    rst,
    input  logic [THREADS-1:0]      req_vld,
    input  logic [32*THREADS-1:0]   req_instr,
    output logic [THREADS-1:0]      req_rdy,
    input  logic                    alu_stall,
    input  logic [THREADS-1:0]      flush,
    input  logic                    trap_val,
    input  logic [THREADS-1:0]      trap_clr,
    output logic                    dec_alu_ex1_act,
    output logic [31:0]             dec_alu_ex1_instr,
    output logic [TID_W-1:0]        ex1_tid,
    output logic [TID_W-1:0]        ex2_tid,
    output logic [TID_W-1:0]        ex3_tid,
    output logic                    ex2_vld,
    output logic                    ex3_vld,
    output logic [THREADS-1:0]      trap_hold,
    output logic                    trap_tid_vld,
    output logic [TID_W-1:0]        trap_tid
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
    localparam logic [TID_W-1:0]   c_last  = TID_W'(THREADS - 1);

    logic [THREADS-1:0]       w_elig;
    logic [THREADS-1:0]       w_kill;
    logic [THREADS-1:0]       w_trap_set_vec;
    logic [THREADS-1:0][31:0] w_head;
    logic                     w_trap_set;
    logic                     w_grant_vld;
    logic [TID_W-1:0]         w_grant_tid;
    logic [TID_W-1:0]         w_idx;

    logic [TID_W-1:0]   r_rr_ptr;
    logic               r_ex1_act;
    logic [31:0]        r_ex1_instr;
    logic [TID_W-1:0]   r_ex1_tid;
    logic               r_ex2_vld;
    logic [TID_W-1:0]   r_ex2_tid;
    logic               r_ex3_vld;
    logic [TID_W-1:0]   r_ex3_tid;
    logic [THREADS-1:0] r_trap_hold;
    logic               r_trap_tid_vld;
    logic [TID_W-1:0]   r_trap_tid;

    // A flushed ex3 op cannot trap; the flush already discards it.
    assign w_trap_set = r_ex3_vld & trap_val & ~flush[r_ex3_tid];

    genvar t;
    generate
        for (t = 0; t < THREADS; t++) begin : g_thread
            localparam logic [TID_W-1:0] c_tid = TID_W'(t);

            logic [31:0]        r_mem [DEPTH];
            logic [c_ptr_w-1:0] r_rd_ptr;
            logic [c_ptr_w-1:0] r_wr_ptr;
            logic [c_cnt_w-1:0] r_count;
            logic               w_push;
            logic               w_pop;

            assign w_trap_set_vec[t] = w_trap_set & (r_ex3_tid == c_tid);
            assign w_kill[t]  = flush[t] | w_trap_set_vec[t];
            assign req_rdy[t] = (r_count < c_depth);
            assign w_elig[t]  = (r_count != '0) & ~r_trap_hold[t] & ~w_kill[t];
            assign w_push     = req_vld[t] & req_rdy[t] & ~w_kill[t];
            assign w_pop      = w_grant_vld & (w_grant_tid == c_tid);
            assign w_head[t]  = r_mem[r_rd_ptr];

            always_ff @(posedge nclk) begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= req_instr[32*t +: 32];
                end
            end

            always_ff @(posedge nclk) begin
                if (rst || w_kill[t]) begin
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                    end
                    case ({w_push, w_pop})
                        2'b10:   r_count <= r_count + c_cnt_w'(1);
                        2'b01:   r_count <= r_count - c_cnt_w'(1);
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_tid = '0;
        w_idx       = '0;
        for (int i = 0; i < THREADS; i++) begin
            w_idx = TID_W'((int'(r_rr_ptr) + i) % THREADS);
            if (!alu_stall && !w_grant_vld && w_elig[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_tid = w_idx;
            end
        end
    end

    always_ff @(posedge nclk) begin
        if (rst) begin
            r_rr_ptr       <= '0;
            r_ex1_act      <= 1'b0;
            r_ex1_instr    <= '0;
            r_ex1_tid      <= '0;
            r_ex2_vld      <= 1'b0;
            r_ex2_tid      <= '0;
            r_ex3_vld      <= 1'b0;
            r_ex3_tid      <= '0;
            r_trap_hold    <= '0;
            r_trap_tid_vld <= 1'b0;
            r_trap_tid     <= '0;
        end else begin
            r_ex1_act <= w_grant_vld;
            if (w_grant_vld) begin
                r_ex1_instr <= w_head[w_grant_tid];
                r_ex1_tid   <= w_grant_tid;
                r_rr_ptr    <= (w_grant_tid == c_last) ? '0 : w_grant_tid + TID_W'(1);
            end
            r_ex2_vld      <= r_ex1_act & ~w_kill[r_ex1_tid];
            r_ex2_tid      <= r_ex1_tid;
            r_ex3_vld      <= r_ex2_vld & ~w_kill[r_ex2_tid];
            r_ex3_tid      <= r_ex2_tid;
            // Set takes priority over a same-cycle clear.
            r_trap_hold    <= (r_trap_hold & ~trap_clr) | w_trap_set_vec;
            r_trap_tid_vld <= w_trap_set;
            if (w_trap_set) begin
                r_trap_tid <= r_ex3_tid;
            end
        end
    end

    assign dec_alu_ex1_act   = r_ex1_act;
    assign dec_alu_ex1_instr = r_ex1_instr;
    assign ex1_tid           = r_ex1_tid;
    assign ex2_tid           = r_ex2_tid;
    assign ex3_tid           = r_ex3_tid;
    assign ex2_vld           = r_ex2_vld;
    assign ex3_vld           = r_ex3_vld;
    assign trap_hold         = r_trap_hold;
    assign trap_tid_vld      = r_trap_tid_vld;
    assign trap_tid          = r_trap_tid;

endmodule
`default_nettype wire

// File: tb/tb_xu_alu_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_xu_alu_sched
// Description : Directed self-checking bench for xu_alu_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xu_alu_sched;

    localparam int THREADS = 4;
    localparam int DEPTH   = 2;
    localparam int TID_W   = 2;

    logic                  nclk;
    logic                  rst;
    logic [THREADS-1:0]    req_vld;
    logic [32*THREADS-1:0] req_instr;
    logic [THREADS-1:0]    req_rdy;
    logic                  alu_stall;
    logic [THREADS-1:0]    flush;
    logic                  trap_val;
    logic [THREADS-1:0]    trap_clr;
    logic                  dec_alu_ex1_act;
    logic [31:0]           dec_alu_ex1_instr;
    logic [TID_W-1:0]      ex1_tid;
    logic [TID_W-1:0]      ex2_tid;
    logic [TID_W-1:0]      ex3_tid;
    logic                  ex2_vld;
    logic                  ex3_vld;
    logic [THREADS-1:0]    trap_hold;
    logic                  trap_tid_vld;
    logic [TID_W-1:0]      trap_tid;

    int n_checks = 0;
    int n_errors = 0;

    xu_alu_sched #(.THREADS(THREADS), .DEPTH(DEPTH), .TID_W(TID_W)) dut (
        .nclk              (nclk),
        .rst               (rst),
        .req_vld           (req_vld),
        .req_instr         (req_instr),
        .req_rdy           (req_rdy),
        .alu_stall         (alu_stall),
        .flush             (flush),
        .trap_val          (trap_val),
        .trap_clr          (trap_clr),
        .dec_alu_ex1_act   (dec_alu_ex1_act),
        .dec_alu_ex1_instr (dec_alu_ex1_instr),
        .ex1_tid           (ex1_tid),
        .ex2_tid           (ex2_tid),
        .ex3_tid           (ex3_tid),
        .ex2_vld           (ex2_vld),
        .ex3_vld           (ex3_vld),
        .trap_hold         (trap_hold),
        .trap_tid_vld      (trap_tid_vld),
        .trap_tid          (trap_tid)
    );

    initial nclk = 1'b0;
    always #5 nclk = ~nclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle outputs.
    task automatic tick();
        @(posedge nclk);
        #1;
    endtask

    initial begin
        int acts;
        int n0, n2, e0, e2, exp_t;
        logic st, p0, p2;

        rst = 1'b1; req_vld = '0; req_instr = '0; alu_stall = 1'b0;
        flush = '0; trap_val = 1'b0; trap_clr = '0;
        tick();
        tick();
        check("rst_rdy",   32'(req_rdy), 32'hF);
        check("rst_act",   32'(dec_alu_ex1_act), 32'd0);
        check("rst_instr", dec_alu_ex1_instr, 32'd0);
        check("rst_ex3",   32'(ex3_vld), 32'd0);
        check("rst_hold",  32'(trap_hold), 32'd0);
        check("rst_ttv",   32'(trap_tid_vld), 32'd0);
        rst = 1'b0;

        // 1: one op per thread in a single cycle, round-robin issue 0..3
        req_vld = 4'hF;
        for (int t = 0; t < THREADS; t++) req_instr[32*t +: 32] = 32'hA000_0000 + 32'(t);
        tick();
        req_vld = '0;
        for (int k = 0; k < 7; k++) begin
            tick();
            check("t1_act", 32'(dec_alu_ex1_act), (k < 4) ? 32'd1 : 32'd0);
            if (k < 4) begin
                check("t1_tid",   32'(ex1_tid), 32'(k));
                check("t1_instr", dec_alu_ex1_instr, 32'hA000_0000 + 32'(k));
            end
            check("t1_ex3v", 32'(ex3_vld), (k >= 2 && k < 6) ? 32'd1 : 32'd0);
            if (k >= 2 && k < 6) check("t1_ex3t", 32'(ex3_tid), 32'(k - 2));
        end

        // 2: thread 1 overfill while issue is stalled
        alu_stall = 1'b1;
        req_vld = 4'b0010;
        req_instr[32 +: 32] = 32'hB000_0000; tick();
        req_instr[32 +: 32] = 32'hB000_0001; tick();
        check("t2_full", 32'(req_rdy), 32'hD);
        req_instr[32 +: 32] = 32'hB000_0002; tick();
        check("t2_full2", 32'(req_rdy), 32'hD);
        req_vld = '0;
        alu_stall = 1'b0;
        acts = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (dec_alu_ex1_act) begin
                check("t2_tid",   32'(ex1_tid), 32'd1);
                check("t2_instr", dec_alu_ex1_instr, (acts == 0) ? 32'hB000_0000 : 32'hB000_0001);
                acts++;
            end
        end
        check("t2_acts", 32'(acts), 32'd2);

        // 3: threads 0 and 2 streaming with a 3-cycle stall
        n0 = 0; n2 = 0; e0 = 0; e2 = 0; exp_t = 2;
        for (int c = 0; c < 14; c++) begin
            p0 = req_rdy[0];
            p2 = req_rdy[2];
            req_vld = {1'b0, p2, 1'b0, p0};
            req_instr[0  +: 32] = 32'hC000_0000 + 32'(n0);
            req_instr[64 +: 32] = 32'hC200_0000 + 32'(n2);
            st = (c >= 6 && c <= 8);
            alu_stall = st;
            tick();
            if (p0) n0++;
            if (p2) n2++;
            if (c >= 1) check("t3_act", 32'(dec_alu_ex1_act), st ? 32'd0 : 32'd1);
            if (dec_alu_ex1_act) begin
                check("t3_tid", 32'(ex1_tid), 32'(exp_t));
                if (exp_t == 0) begin
                    check("t3_instr0", dec_alu_ex1_instr, 32'hC000_0000 + 32'(e0));
                    e0++;
                    exp_t = 2;
                end else begin
                    check("t3_instr2", dec_alu_ex1_instr, 32'hC200_0000 + 32'(e2));
                    e2++;
                    exp_t = 0;
                end
            end
        end
        req_vld = '0; alu_stall = 1'b0;
        flush = 4'b0101;
        tick();
        flush = '0;
        check("t3_flush_act", 32'(dec_alu_ex1_act), 32'd0);
        tick(); tick(); tick();
        check("t3_drained", 32'(ex3_vld), 32'd0);

        // 4: flush thread 2 in ex2 while thread 3 sits in ex1
        req_vld = 4'b1100;
        req_instr[64 +: 32] = 32'hD200_0000;
        req_instr[96 +: 32] = 32'hD300_0000;
        tick();
        req_vld = 4'b0100;
        req_instr[64 +: 32] = 32'hD200_0001;
        tick();
        req_vld = '0;
        check("t4_ex1_2", 32'(ex1_tid), 32'd2);
        tick();
        check("t4_ex1_3", 32'(ex1_tid), 32'd3);
        check("t4_ex2_2", 32'(ex2_tid), 32'd2);
        flush = 4'b0100;
        tick();
        flush = '0;
        check("t4_ex3v", 32'(ex3_vld), 32'd0);
        check("t4_ex2v", 32'(ex2_vld), 32'd1);
        check("t4_ex2t", 32'(ex2_tid), 32'd3);
        tick();
        check("t4_ex3_3", {31'd0, ex3_vld} | (32'(ex3_tid) << 4), 32'h31);
        check("t4_fifo_empty", 32'(dec_alu_ex1_act), 32'd0);
        tick();
        check("t4_fifo_empty2", 32'(dec_alu_ex1_act), 32'd0);

        // 5: trap on thread 1
        trap_val = 1'b1;
        tick();
        trap_val = 1'b0;
        check("t5_ign_ttv",  32'(trap_tid_vld), 32'd0);
        check("t5_ign_hold", 32'(trap_hold), 32'd0);
        req_vld = 4'b0010;
        req_instr[32 +: 32] = 32'hE100_0000;
        tick();
        req_vld = '0;
        tick();
        check("t5_iss", 32'(ex1_tid), 32'd1);
        tick(); tick();
        check("t5_ex3", {31'd0, ex3_vld} | (32'(ex3_tid) << 4), 32'h11);
        trap_val = 1'b1;
        tick();
        trap_val = 1'b0;
        check("t5_ttv",  32'(trap_tid_vld), 32'd1);
        check("t5_ttid", 32'(trap_tid), 32'd1);
        check("t5_hold", 32'(trap_hold), 32'h2);
        tick();
        check("t5_pulse", 32'(trap_tid_vld), 32'd0);
        check("t5_hold2", 32'(trap_hold), 32'h2);
        req_vld = 4'b0010;
        req_instr[32 +: 32] = 32'hF100_0000;
        tick();
        req_vld = '0;
        check("t5_rdy", 32'(req_rdy), 32'hF);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_blocked", 32'(dec_alu_ex1_act), 32'd0);
        end
        trap_clr = 4'b0010;
        tick();
        trap_clr = '0;
        check("t5_clr", 32'(trap_hold), 32'd0);
        check("t5_clr_act", 32'(dec_alu_ex1_act), 32'd0);
        tick();
        check("t5_resume", 32'(dec_alu_ex1_act), 32'd1);
        check("t5_res_tid", 32'(ex1_tid), 32'd1);
        check("t5_res_ins", dec_alu_ex1_instr, 32'hF100_0000);

        // 6: simultaneous set/clear on thread 0, push+flush on thread 3
        req_vld = 4'b0001;
        req_instr[0 +: 32] = 32'h6000_0000;
        tick();
        req_vld = '0;
        tick();
        check("t6_iss", 32'(ex1_tid), 32'd0);
        tick(); tick();
        check("t6_ex3", {31'd0, ex3_vld} | (32'(ex3_tid) << 4), 32'h01);
        trap_val = 1'b1; trap_clr = 4'b0001;
        req_vld = 4'b1000; flush = 4'b1000;
        req_instr[96 +: 32] = 32'h6300_0000;
        tick();
        trap_val = 1'b0; trap_clr = '0; req_vld = '0; flush = '0;
        check("t6_hold", 32'(trap_hold), 32'h1);
        check("t6_ttid", 32'(trap_tid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_noact", 32'(dec_alu_ex1_act), 32'd0);
        end

        // Reset mid-operation discards buffered work and trap hold
        req_vld = 4'b0100;
        req_instr[64 +: 32] = 32'h7200_0000;
        tick();
        req_vld = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("r_hold", 32'(trap_hold), 32'd0);
        check("r_act",  32'(dec_alu_ex1_act), 32'd0);
        tick();
        check("r_discard", 32'(dec_alu_ex1_act), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
